// File: rtl/fp_normalize_round.sv
// Iterative normalize-and-round stage for the binary32 adder: shifts the raw
// mantissa sum one bit per cycle, rounds to nearest-even and packs the result.
module fp_normalize_round (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic        signIn,
    input  logic [7:0]  exponentIn,
    input  logic [24:0] sumMantissa,
    input  logic        guardBit,
    input  logic        roundBit,
    input  logic        stickyBit,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        NORMALIZE = 2'd1,
        ROUND     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t      state_r, nextState_s;
    logic [24:0] mant_r, nextMant_s;
    logic [8:0]  exp_r, nextExp_s;
    logic        g_r, r_r, s_r, sign_r;
    logic        nextG_s, nextR_s, nextS_s, nextSign_s;
    logic [4:0]  shiftCnt_r, nextShiftCnt_s;
    logic [31:0] result_r, nextResult_s;
    logic        overflow_r, nextOverflow_s;
    logic        underflow_r, nextUnderflow_s;
    logic        outValid_r, nextOutValid_s;
    logic        inReady_r, nextInReady_s;

    logic        roundInc_s;
    logic [24:0] roundSum_s;
    logic [24:0] roundMant_s;
    logic [8:0]  roundExp_s;

    // Round-to-nearest-even increment and the post-round renormalization.
    always_comb begin
        roundInc_s  = g_r & (r_r | s_r | mant_r[0]);
        roundSum_s  = mant_r + {24'd0, roundInc_s};
        roundMant_s = roundSum_s;
        roundExp_s  = exp_r;
        if (roundSum_s[24]) begin
            roundMant_s = {1'b0, roundSum_s[24:1]};
            roundExp_s  = exp_r + 9'd1;
        end else begin
            roundMant_s = roundSum_s;
            roundExp_s  = exp_r;
        end
    end

    // Next-state and datapath update for each FSM state.
    always_comb begin
        nextState_s     = state_r;
        nextMant_s      = mant_r;
        nextExp_s       = exp_r;
        nextG_s         = g_r;
        nextR_s         = r_r;
        nextS_s         = s_r;
        nextSign_s      = sign_r;
        nextShiftCnt_s  = shiftCnt_r;
        nextResult_s    = result_r;
        nextOverflow_s  = overflow_r;
        nextUnderflow_s = underflow_r;
        case (state_r)
            IDLE: begin
                if (inValid) begin
                    nextOverflow_s  = 1'b0;
                    nextUnderflow_s = 1'b0;
                    nextShiftCnt_s  = 5'd0;
                    nextState_s     = NORMALIZE;
                    // A zero exponent is loaded as an exact zero so it exits on the first normalize cycle.
                    if (exponentIn == 8'd0) begin
                        nextSign_s = 1'b0;
                        nextExp_s  = 9'd0;
                        nextMant_s = 25'd0;
                        nextG_s    = 1'b0;
                        nextR_s    = 1'b0;
                        nextS_s    = 1'b0;
                    end else begin
                        nextSign_s = signIn;
                        nextExp_s  = {1'b0, exponentIn};
                        nextMant_s = sumMantissa;
                        nextG_s    = guardBit;
                        nextR_s    = roundBit;
                        nextS_s    = stickyBit;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            NORMALIZE: begin
                if (mant_r[24]) begin
                    nextMant_s = {1'b0, mant_r[24:1]};
                    nextG_s    = mant_r[0];
                    nextR_s    = g_r;
                    nextS_s    = r_r | s_r;
                    nextExp_s  = exp_r + 9'd1;
                    if ((exp_r + 9'd1) == 9'd255) begin
                        nextOverflow_s = 1'b1;
                        nextResult_s   = {sign_r, 8'hFF, 23'd0};
                        nextState_s    = DONE;
                    end else begin
                        nextState_s = ROUND;
                    end
                end else if (mant_r[23]) begin
                    nextState_s = ROUND;
                end else if ((mant_r == 25'd0) && !g_r && !r_r && !s_r) begin
                    nextResult_s = 32'd0;
                    nextState_s  = DONE;
                end else if ((exp_r == 9'd1) || (shiftCnt_r == 5'd24)) begin
                    // Shift budget is capped at 24; anything still unnormalized is too small to represent.
                    nextUnderflow_s = 1'b1;
                    nextResult_s    = {sign_r, 31'd0};
                    nextState_s     = DONE;
                end else begin
                    nextMant_s     = {mant_r[23:0], g_r};
                    nextG_s        = r_r;
                    nextR_s        = 1'b0;
                    nextExp_s      = exp_r - 9'd1;
                    nextShiftCnt_s = shiftCnt_r + 5'd1;
                end
            end
            ROUND: begin
                nextMant_s  = roundMant_s;
                nextExp_s   = roundExp_s;
                nextState_s = DONE;
                if (roundExp_s >= 9'd255) begin
                    nextOverflow_s = 1'b1;
                    nextResult_s   = {sign_r, 8'hFF, 23'd0};
                end else begin
                    nextResult_s = {sign_r, roundExp_s[7:0], roundMant_s[22:0]};
                end
            end
            DONE: begin
                if (outValid_r && outReady) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = DONE;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // Handshake outputs: the first DONE cycle loads outValid, which then holds until accepted.
    always_comb begin
        nextOutValid_s = (state_r == DONE) && (nextState_s == DONE);
        nextInReady_s  = (nextState_s == IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            mant_r      <= 25'd0;
            exp_r       <= 9'd0;
            g_r         <= 1'b0;
            r_r         <= 1'b0;
            s_r         <= 1'b0;
            sign_r      <= 1'b0;
            shiftCnt_r  <= 5'd0;
            result_r    <= 32'd0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            outValid_r  <= 1'b0;
            inReady_r   <= 1'b1;
        end else begin
            state_r     <= nextState_s;
            mant_r      <= nextMant_s;
            exp_r       <= nextExp_s;
            g_r         <= nextG_s;
            r_r         <= nextR_s;
            s_r         <= nextS_s;
            sign_r      <= nextSign_s;
            shiftCnt_r  <= nextShiftCnt_s;
            result_r    <= nextResult_s;
            overflow_r  <= nextOverflow_s;
            underflow_r <= nextUnderflow_s;
            outValid_r  <= nextOutValid_s;
            inReady_r   <= nextInReady_s;
        end
    end

    assign inReady   = inReady_r;
    assign outValid  = outValid_r;
    assign result    = result_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule
